// File: rtl/axi_ram_pkg.sv
// Shared types and helpers for the AXI4-Lite RAM controller slice.
package axi_ram_pkg;

    localparam int BYTE_BITS = 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } ctrl_state_e;

    // Byte-offset bits dropped from the AXI byte address to form a word address.
    function automatic int calc_off(input int data_width);
        return $clog2(data_width / BYTE_BITS);
    endfunction

endpackage

// File: rtl/axi_ram_rr_arb.sv
// Two-requester round-robin arbiter: write vs read. The pointer only moves
// when both request together, so an uncontended grant never shifts priority.
module axi_ram_rr_arb (
    input  logic aclk,
    input  logic aresetn,
    input  logic req_wr,
    input  logic req_rd,
    output logic grant_wr,
    output logic grant_rd
);

    logic rd_prio_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_prio_reg <= 1'b0;
        end else if (req_wr && req_rd) begin
            rd_prio_reg <= !rd_prio_reg;
        end
    end

    always_comb begin
        grant_wr = req_wr && (!req_rd || !rd_prio_reg);
        grant_rd = req_rd && (!req_wr || rd_prio_reg);
    end

endmodule

// File: rtl/axi_lite_ram_ctrl.sv
// AXI4-Lite slave sequencing one RAM port, one transaction in flight at a time.
// Define AXI_RAM_SLVERR_EN to reject addresses with non-zero bits above the RAM range.
module axi_lite_ram_ctrl
    import axi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int AXI_ADDR_WIDTH = 12
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_din,
    input  logic [DATA_WIDTH-1:0]     ram_dout
);

    localparam int OFF    = calc_off(DATA_WIDTH);
    localparam int STRB_W = DATA_WIDTH / BYTE_BITS;

    ctrl_state_e               state_reg, state_next;
    logic                      rst_done_reg;
    logic                      aw_full_reg, w_full_reg, ar_full_reg;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_reg, ar_addr_reg;
    logic [DATA_WIDTH-1:0]     w_data_reg;
    logic [STRB_W-1:0]         w_strb_reg;
    logic                      err_reg, err_next;
    logic                      ram_en_reg, ram_en_next;
    logic                      ram_we_reg, ram_we_next;
    logic [ADDR_WIDTH-1:0]     ram_addr_reg, ram_addr_next;
    logic [DATA_WIDTH-1:0]     ram_din_reg, ram_din_next;
    logic                      bvalid_reg, bvalid_next;
    resp_e                     bresp_reg, bresp_next;
    logic                      rvalid_reg, rvalid_next;
    resp_e                     rresp_reg, rresp_next;
    logic [DATA_WIDTH-1:0]     rdata_reg, rdata_next;
    logic                      wr_clr, ar_clr;
    logic                      req_wr, req_rd, grant_wr, grant_rd;
    logic                      aw_err, ar_err;

    // Readies stay low while reset is held and for the release edge.
    assign s_awready = rst_done_reg && !aw_full_reg;
    assign s_wready  = rst_done_reg && !w_full_reg;
    assign s_arready = rst_done_reg && !ar_full_reg;

    assign s_bvalid = bvalid_reg;
    assign s_bresp  = bresp_reg;
    assign s_rvalid = rvalid_reg;
    assign s_rresp  = rresp_reg;
    assign s_rdata  = rdata_reg;
    assign ram_en   = ram_en_reg;
    assign ram_we   = ram_we_reg;
    assign ram_addr = ram_addr_reg;
    assign ram_din  = ram_din_reg;

`ifdef AXI_RAM_SLVERR_EN
    assign aw_err = |(aw_addr_reg >> (OFF + ADDR_WIDTH));
    assign ar_err = |(ar_addr_reg >> (OFF + ADDR_WIDTH));
`else
    // Upper address bits alias onto the RAM; they are held but never decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aw_addr_reg, ar_addr_reg};
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    assign req_wr = (state_reg == IDLE) && aw_full_reg && w_full_reg;
    assign req_rd = (state_reg == IDLE) && ar_full_reg;

    axi_ram_rr_arb u_arb (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .req_wr   (req_wr),
        .req_rd   (req_rd),
        .grant_wr (grant_wr),
        .grant_rd (grant_rd)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_done_reg <= 1'b0;
            aw_full_reg  <= 1'b0;
            w_full_reg   <= 1'b0;
            ar_full_reg  <= 1'b0;
            aw_addr_reg  <= '0;
            ar_addr_reg  <= '0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
        end else begin
            rst_done_reg <= 1'b1;
            if (s_awvalid && s_awready) begin
                aw_full_reg <= 1'b1;
                aw_addr_reg <= s_awaddr;
            end else if (wr_clr) begin
                aw_full_reg <= 1'b0;
            end
            if (s_wvalid && s_wready) begin
                w_full_reg <= 1'b1;
                w_data_reg <= s_wdata;
                w_strb_reg <= s_wstrb;
            end else if (wr_clr) begin
                w_full_reg <= 1'b0;
            end
            if (s_arvalid && s_arready) begin
                ar_full_reg <= 1'b1;
                ar_addr_reg <= s_araddr;
            end else if (ar_clr) begin
                ar_full_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg    <= IDLE;
            err_reg      <= 1'b0;
            ram_en_reg   <= 1'b0;
            ram_we_reg   <= 1'b0;
            ram_addr_reg <= '0;
            ram_din_reg  <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= OKAY;
            rvalid_reg   <= 1'b0;
            rresp_reg    <= OKAY;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            err_reg      <= err_next;
            ram_en_reg   <= ram_en_next;
            ram_we_reg   <= ram_we_next;
            ram_addr_reg <= ram_addr_next;
            ram_din_reg  <= ram_din_next;
            bvalid_reg   <= bvalid_next;
            bresp_reg    <= bresp_next;
            rvalid_reg   <= rvalid_next;
            rresp_reg    <= rresp_next;
            rdata_reg    <= rdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        err_next      = err_reg;
        ram_en_next   = 1'b0;
        ram_we_next   = 1'b0;
        ram_addr_next = ram_addr_reg;
        ram_din_next  = ram_din_reg;
        bvalid_next   = bvalid_reg;
        bresp_next    = bresp_reg;
        rvalid_next   = rvalid_reg;
        rresp_next    = rresp_reg;
        rdata_next    = rdata_reg;
        wr_clr        = 1'b0;
        ar_clr        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_wr) begin
                    state_next    = WR_ISSUE;
                    err_next      = aw_err;
                    ram_en_next   = !aw_err;
                    ram_we_next   = !aw_err && (|w_strb_reg);
                    ram_addr_next = aw_addr_reg[OFF +: ADDR_WIDTH];
                    ram_din_next  = w_data_reg;
                end else if (grant_rd) begin
                    state_next    = RD_ISSUE;
                    err_next      = ar_err;
                    ram_en_next   = !ar_err;
                    ram_addr_next = ar_addr_reg[OFF +: ADDR_WIDTH];
                end
            end
            WR_ISSUE: begin
                wr_clr      = 1'b1;
                bvalid_next = 1'b1;
                bresp_next  = err_reg ? SLVERR : OKAY;
                state_next  = WR_RESP;
            end
            WR_RESP: begin
                if (s_bready) begin
                    bvalid_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            RD_ISSUE: begin
                ar_clr     = 1'b1;
                state_next = RD_WAIT;
            end
            // RAM output becomes valid during this state; capture it on exit.
            RD_WAIT: begin
                rvalid_next = 1'b1;
                rdata_next  = err_reg ? '0 : ram_dout;
                rresp_next  = err_reg ? SLVERR : OKAY;
                state_next  = RD_RESP;
            end
            RD_RESP: begin
                if (s_rready) begin
                    rvalid_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
